// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, owner
// encoding and the default memory latency.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_NIC = 1'b1
  } owner_e;

  localparam int unsigned MEM_LAT_DEF = 1;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 64;
  // Wide enough for the largest legal latency (15)
  localparam int unsigned LAT_W       = 4;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-requester grant (CPU vs NIC).
// DMEM_ARB_FAIR_EN defined: round-robin on ties; undefined: CPU has fixed priority.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic   req_cpu_i,
  input  logic   req_nic_i,
  input  owner_e last_grant_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  always_comb begin
    gnt_valid_o = req_cpu_i | req_nic_i;
    gnt_owner_o = OWN_CPU;
`ifdef DMEM_ARB_FAIR_EN
    // On a tie the requester that did not win last time goes next
    if (req_cpu_i && req_nic_i) begin
      gnt_owner_o = (last_grant_i == OWN_CPU) ? OWN_NIC : OWN_CPU;
    end else if (req_nic_i) begin
      gnt_owner_o = OWN_NIC;
    end
`else
    if (!req_cpu_i && req_nic_i) begin
      gnt_owner_o = OWN_NIC;
    end
`endif
  end

`ifndef DMEM_ARB_FAIR_EN
  owner_e unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between CPU and NIC and sequences
// each access through a fixed-latency memory. Arbitration policy: DMEM_ARB_FAIR_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              nic_req,
  input  logic              nic_we,
  input  logic [ADDR_W-1:0] nic_addr,
  input  logic [DATA_W-1:0] nic_wdata,
  output logic              nic_done,
  output logic [DATA_W-1:0] nic_rdata,
  output logic              dmem_en,
  output logic              dmem_wr_en,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  input  logic [DATA_W-1:0] dmem_dout
);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_grant_q, last_grant_d;
  logic               we_q, we_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               dmem_en_q, dmem_en_d;
  logic               dmem_wr_en_q, dmem_wr_en_d;
  logic [ADDR_W-1:0]  dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]  dmem_din_q, dmem_din_d;
  logic               cpu_done_q, cpu_done_d;
  logic               nic_done_q, nic_done_d;

  logic               gnt_valid;
  owner_e             gnt_owner;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  rr_arb2 u_arb (
    .req_cpu_i    (cpu_req),
    .req_nic_i    (nic_req),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_owner_o  (gnt_owner)
  );

  always_comb begin
    sel_we    = (gnt_owner == OWN_NIC) ? nic_we    : cpu_we;
    sel_addr  = (gnt_owner == OWN_NIC) ? nic_addr  : cpu_addr;
    sel_wdata = (gnt_owner == OWN_NIC) ? nic_wdata : cpu_wdata;
  end

  // State and datapath registers; reset drops every strobe immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_NIC;
      we_q         <= 1'b0;
      lat_cnt_q    <= '0;
      rdata_q      <= '0;
      dmem_en_q    <= 1'b0;
      dmem_wr_en_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_din_q   <= '0;
      cpu_done_q   <= 1'b0;
      nic_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      lat_cnt_q    <= lat_cnt_d;
      rdata_q      <= rdata_d;
      dmem_en_q    <= dmem_en_d;
      dmem_wr_en_q <= dmem_wr_en_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_din_q   <= dmem_din_d;
      cpu_done_q   <= cpu_done_d;
      nic_done_q   <= nic_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed one cycle ahead of the state they belong to
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    lat_cnt_d    = lat_cnt_q;
    rdata_d      = rdata_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_din_d   = dmem_din_q;
    dmem_en_d    = 1'b0;
    dmem_wr_en_d = 1'b0;
    cpu_done_d   = 1'b0;
    nic_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_owner;
          we_d         = sel_we;
          dmem_addr_d  = sel_addr;
          dmem_din_d   = sel_wdata;
          dmem_en_d    = 1'b1;
          dmem_wr_en_d = sel_we;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end else begin
          if (!we_q) rdata_d = dmem_dout;
          cpu_done_d = (owner_q == OWN_CPU);
          nic_done_d = (owner_q == OWN_NIC);
        end
      end
      DONE: begin
        last_grant_d = owner_q;
      end
      default: ;
    endcase
  end

  assign dmem_en    = dmem_en_q;
  assign dmem_wr_en = dmem_wr_en_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_din   = dmem_din_q;
  assign cpu_done   = cpu_done_q;
  assign nic_done   = nic_done_q;
  assign cpu_rdata  = rdata_q;
  assign nic_rdata  = rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a completion scoreboard and a
// behavioural fixed-latency memory; second instance exercises MEM_LAT=4.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] V10  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [DW-1:0] V30  = 64'h3030_3030_0000_0030;
  localparam logic [DW-1:0] V40  = 64'h4040_4040_0000_0040;
  localparam logic [DW-1:0] V50  = 64'h5050_5050_0000_0050;
  localparam logic [DW-1:0] V4   = 64'hC0DE_0000_0000_0077;
  localparam logic [DW-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, nic_req, nic_we;
  logic [AW-1:0] cpu_addr, nic_addr;
  logic [DW-1:0] cpu_wdata, nic_wdata;
  logic          cpu_stall, cpu_done, nic_done;
  logic [DW-1:0] cpu_rdata, nic_rdata;
  logic          dmem_en, dmem_wr_en;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_din, dmem_dout;

  logic          cpu_req4;
  logic          cpu_stall4, cpu_done4, nic_done4;
  logic [DW-1:0] cpu_rdata4, unused_nrd4;
  logic          dmem_en4, dmem_wr_en4;
  logic [AW-1:0] dmem_addr4;
  logic [DW-1:0] unused_din4, dmem_dout4;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_LAT(1), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .nic_req(nic_req), .nic_we(nic_we), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
    .nic_done(nic_done), .nic_rdata(nic_rdata),
    .dmem_en(dmem_en), .dmem_wr_en(dmem_wr_en), .dmem_addr(dmem_addr),
    .dmem_din(dmem_din), .dmem_dout(dmem_dout)
  );

  dmem_arbiter #(.MEM_LAT(4), .ADDR_W(AW), .DATA_W(DW)) u_dut4 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req4), .cpu_we(1'b0), .cpu_addr(16'h0077), .cpu_wdata('0),
    .cpu_stall(cpu_stall4), .cpu_rdata(cpu_rdata4), .cpu_done(cpu_done4),
    .nic_req(1'b0), .nic_we(1'b0), .nic_addr('0), .nic_wdata('0),
    .nic_done(nic_done4), .nic_rdata(unused_nrd4),
    .dmem_en(dmem_en4), .dmem_wr_en(dmem_wr_en4), .dmem_addr(dmem_addr4),
    .dmem_din(unused_din4), .dmem_dout(dmem_dout4)
  );

  // Memory for the MEM_LAT=1 instance: data valid only in the cycle after the command
  logic [DW-1:0] mem [0:65535];
  logic          rd_v = 1'b0;
  logic [DW-1:0] rd_d = '0;
  always @(posedge clk) begin
    rd_v <= dmem_en & ~dmem_wr_en;
    rd_d <= mem[dmem_addr];
    if (dmem_en && dmem_wr_en) mem[dmem_addr] = dmem_din;
  end
  assign dmem_dout = rd_v ? rd_d : JUNK;

  // Memory for the MEM_LAT=4 instance: data valid only 4 cycles after the command
  logic [3:0] v4 = '0;
  always @(posedge clk) v4 <= {v4[2:0], dmem_en4 & ~dmem_wr_en4};
  assign dmem_dout4 = v4[3] ? V4 : JUNK;

  typedef struct packed {
    logic          nic;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every done pops the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (cpu_done || nic_done)) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed done cpu=%0b nic=%0b expected none", cpu_done, nic_done);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_owner", DW'(nic_done), DW'(e.nic));
        check("sb_rdata", nic_done ? nic_rdata : cpu_rdata, e.rdata);
      end
    end
  end

  task automatic wait_done(input bit want_nic, input bit stall_hi, input bit no_nic, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (stall_hi) check({tag, "_stall"}, DW'(cpu_stall), DW'(1));
      if (no_nic)   check({tag, "_nonic"}, DW'(nic_done), DW'(0));
      seen = want_nic ? nic_done : cpu_done;
    end
    n_chk++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed no done expected done within 40 cycles", tag);
    end
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    nic_req = 1'b0; nic_we = 1'b0; nic_addr = '0; nic_wdata = '0;
    cpu_req4 = 1'b0;
    mem[16'h0010] = V10;
    mem[16'h0030] = V30;
    mem[16'h0040] = V40;
    mem[16'h0050] = V50;

    repeat (2) @(negedge clk);
    check("rst_dmem_en",   DW'(dmem_en),    DW'(0));
    check("rst_dmem_wr",   DW'(dmem_wr_en), DW'(0));
    check("rst_cpu_done",  DW'(cpu_done),   DW'(0));
    check("rst_nic_done",  DW'(nic_done),   DW'(0));
    check("rst_dmem_addr", DW'(dmem_addr),  DW'(0));
    check("rst_rdata",     cpu_rdata,       DW'(0));
    check("rst_stall",     DW'(cpu_stall),  DW'(0));
    @(negedge clk); reset = 1'b0;

    // Single CPU load, MEM_LAT=1
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    sb.push_back('{nic: 1'b0, rdata: V10});
    #1;
    check("t1_stall_c0", DW'(cpu_stall), DW'(1));
    check("t1_en_c0",    DW'(dmem_en),   DW'(0));
    @(negedge clk); #1;
    check("t1_stall_c1", DW'(cpu_stall),  DW'(1));
    check("t1_en_c1",    DW'(dmem_en),    DW'(1));
    check("t1_wr_c1",    DW'(dmem_wr_en), DW'(0));
    check("t1_addr_c1",  DW'(dmem_addr),  DW'(16'h0010));
    @(negedge clk); #1;
    check("t1_stall_c2", DW'(cpu_stall), DW'(1));
    check("t1_en_c2",    DW'(dmem_en),   DW'(0));
    check("t1_done_c2",  DW'(cpu_done),  DW'(0));
    @(negedge clk); #1;
    check("t1_done_c3",  DW'(cpu_done),  DW'(1));
    check("t1_rdata_c3", cpu_rdata,      V10);
    check("t1_stall_c3", DW'(cpu_stall), DW'(0));
    @(negedge clk); cpu_req = 1'b0;

    // CPU store; load data register must keep the previous load value
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 64'h1234;
    sb.push_back('{nic: 1'b0, rdata: V10});
    @(negedge clk); #1;
    check("t2_en",   DW'(dmem_en),    DW'(1));
    check("t2_wr",   DW'(dmem_wr_en), DW'(1));
    check("t2_addr", DW'(dmem_addr),  DW'(16'h0020));
    check("t2_din",  dmem_din,        64'h1234);
    wait_done(1'b0, 1'b0, 1'b0, "t2");

    // NIC reads back the stored value
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    nic_req = 1'b1; nic_we = 1'b0; nic_addr = 16'h0020;
    sb.push_back('{nic: 1'b1, rdata: 64'h1234});
    wait_done(1'b1, 1'b0, 1'b0, "t3");
    check("t3_nic_rdata", nic_rdata, 64'h1234);
    @(negedge clk); nic_req = 1'b0;

    // Simultaneous CPU and NIC requests
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0030;
    nic_req = 1'b1; nic_addr = 16'h0040;
`ifdef DMEM_ARB_FAIR_EN
    sb.push_back('{nic: 1'b0, rdata: V30});
    sb.push_back('{nic: 1'b1, rdata: V40});
    #1;
    check("t4_stall_c0", DW'(cpu_stall), DW'(1));
    wait_done(1'b0, 1'b0, 1'b0, "t4_cpu1");
    @(negedge clk); cpu_addr = 16'h0050;
    sb.push_back('{nic: 1'b0, rdata: V50});
    wait_done(1'b1, 1'b1, 1'b0, "t4_nic");
    @(negedge clk); nic_req = 1'b0;
    wait_done(1'b0, 1'b0, 1'b0, "t4_cpu2");
    @(negedge clk); cpu_req = 1'b0;
`else
    sb.push_back('{nic: 1'b0, rdata: V30});
    wait_done(1'b0, 1'b0, 1'b1, "t4_cpu1");
    @(negedge clk); cpu_addr = 16'h0050;
    sb.push_back('{nic: 1'b0, rdata: V50});
    wait_done(1'b0, 1'b0, 1'b1, "t4_cpu2");
    @(negedge clk); cpu_req = 1'b0;
    sb.push_back('{nic: 1'b1, rdata: V40});
    wait_done(1'b1, 1'b0, 1'b0, "t4_nic");
    @(negedge clk); nic_req = 1'b0;
`endif

    // MEM_LAT=4 instance: done 6 cycles after request, data sampled 4 cycles after dmem_en
    @(negedge clk);
    cpu_req4 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        check("t5_en_c1",   DW'(dmem_en4),   DW'(1));
        check("t5_addr_c1", DW'(dmem_addr4), DW'(16'h0077));
      end
      if (c == 2) check("t5_en_c2", DW'(dmem_en4), DW'(0));
      if (cpu_done4) lat = c;
      else check("t5_stall", DW'(cpu_stall4), DW'(1));
    end
    check("t5_latency", DW'(lat),  DW'(6));
    check("t5_rdata",   cpu_rdata4, V4);
    check("t5_nonic",   DW'(nic_done4), DW'(0));
    @(negedge clk); cpu_req4 = 1'b0;

    // Reset while main instance is in WAIT and the LAT=4 instance is in ISSUE
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    @(negedge clk);
    cpu_req4 = 1'b1;
    @(negedge clk); #1;
    check("t6_pre_addr", DW'(dmem_addr), DW'(16'h0010));
    check("t6_pre_en4",  DW'(dmem_en4),  DW'(1));
    reset = 1'b1;
    sb.delete();
    #1;
    check("t6_rst_en4",   DW'(dmem_en4),  DW'(0));
    check("t6_rst_addr",  DW'(dmem_addr), DW'(0));
    check("t6_rst_rdata", cpu_rdata,      DW'(0));
    check("t6_rst_done",  DW'(cpu_done),  DW'(0));
    check("t6_rst_stall", DW'(cpu_stall), DW'(1));
    cpu_req4 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{nic: 1'b0, rdata: V10});
    lat = -1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(negedge clk); #1;
      if (cpu_done) lat = c;
    end
    check("t6_latency", DW'(lat), DW'(3));
    @(negedge clk); cpu_req = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_empty", DW'(sb.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
